spi_shift_transmitter: RTL and testbench
========================================

Name: spi_shift_transmitter

Overview:
- Parametrised SPI slave transmit path. Drives MOSI/MISO-side serial data from a word-wide double buffer, one bit per detected SCL shift edge, while the enable (chip-select window) is high.
- Successor to the fixed 8-bit transmitter. Adds:
  - configurable width and bit order
  - configurable idle level
  - a valid/ready load handshake with a holding register, for back-to-back words
  - load pulse and underrun reporting
- Sits between the register/FIFO side and the SCL edge detector in the SPI slave.

Parameters:
- DATA_WIDTH, 8, word length in bits, 2..32.
- MSB_FIRST, 1, 1 = data_i[DATA_WIDTH-1] shifted first; 0 = data_i[0] first.
- IDLE_LEVEL, 1'b1, level driven on mosi_o when idle, disabled, or underrunning.

Ports:
- clk_i, input, 1, system clock; all logic on its rising edge.
- reset_n_i, input, 1, synchronous, active-low reset.
- en_i, input, 1, transfer enable (chip-select active), synchronous to clk_i.
- scl_neg_edge_detected_i, input, 1, one-cycle pulse per SCL shift edge.
- data_i, input, DATA_WIDTH, word to transmit.
- data_valid_i, input, 1, data_i valid.
- data_ready_o, output, 1, holding register empty; word accepted when data_valid_i && data_ready_o at a clock edge.
- load_o, output, 1, one-cycle pulse when a word moves from the holding register into the shifter.
- underrun_o, output, 1, underrun indication; behaviour set by the optional feature.
- mosi_o, output, 1, serial data out, registered.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - hold_full=0, shifter=0, bit_cnt=0, en_d=0.
  - mosi_o=IDLE_LEVEL, load_o=0, underrun_o=0.
  - data_ready_o=1 after reset. It is combinationally ~hold_full.
- Holding register:
  - Loaded on an accepted handshake. It is loaded and retained regardless of en_i, so the word can be preloaded before the enable rises.
  - Acceptance and consumption cannot coincide, because ready=0 while full.
- Enable edge: en_d registers en_i. en_rise = en_i & ~en_d.
- Shift event: event = en_i & (en_rise | scl_neg_edge_detected_i). An en_rise coinciding with a SCL pulse counts as one event.
- en_i=0:
  - bit_cnt=0, mosi_o=IDLE_LEVEL.
  - Any partial word in the shifter is discarded. The holding register is untouched.
  - load_o=0.
- Event with bit_cnt==0 and hold_full=1:
  - Shifter gets the holding register, and hold_full is cleared.
  - mosi_o gets the first bit per MSB_FIRST.
  - bit_cnt = DATA_WIDTH-1.
  - load_o=1 for that cycle.
- Event with bit_cnt==0 and hold_full=0: underrun. mosi_o=IDLE_LEVEL, bit_cnt stays 0.
- Event with bit_cnt>0:
  - mosi_o gets the next bit. Shift left if MSB_FIRST, else right.
  - bit_cnt decrements.
- No event: all state holds.
- Latency: mosi_o changes exactly one clk_i cycle after the event pulse.
- Back-to-back words: the event after the last bit of word N loads word N+1 with no gap, provided word N+1 is in the holding register by that edge.
- bit_cnt width: $clog2(DATA_WIDTH+1). It never wraps.
- reset_n_i low mid-frame overrides everything; all state returns to reset values on the next edge.

Optional Feature:
- Macro: SPI_TX_UNDERRUN_FLAG_EN.
- Defined:
  - underrun_o is a sticky flag, set on any underrun event.
  - It is cleared only by reset or by en_rise. If an underrun occurs on the en_rise event itself, the set wins.
- Not defined: underrun_o is tied to 0, and the flag logic is absent. Underrun data behaviour (IDLE_LEVEL on mosi_o) is identical either way.

Test Plan:
- Default params: preload 8'hA5, raise en_i, then 7 SCL pulses -> mosi_o = 1,0,1,0,0,1,0,1, each one cycle after its event; load_o pulses once, on the en_rise event; data_ready_o returns to 1 on the load.
- MSB_FIRST=0, DATA_WIDTH=12: preload 12'h0F3, en_rise plus 11 pulses -> bits 1,1,0,0,1,1,1,1,0,0,0,0.
- Back-to-back: preload 8'hFF; after the load, present 8'h00 -> on the 8th SCL pulse mosi_o=0 with a load_o pulse and no idle bit between words.
- Underrun (macro defined): en_rise with the holding register empty -> mosi_o=IDLE_LEVEL, load_o=0, underrun_o=1. The flag stays 1 until the next en_rise.
- Abort: drop en_i after 3 bits of 8'h3C, with 8'h81 held -> mosi_o=IDLE_LEVEL. The next en_rise transmits 8'h81 from bit 7.
- Reset mid-frame: assert reset_n_i=0 for 1 cycle during bit 4 -> mosi_o=1, data_ready_o=1, underrun_o=0, and no load_o until a new handshake.

Source files
------------

// File: rtl/spi_shift_transmitter.sv
// SPI slave transmit shifter fed from a valid/ready holding register.
// Define SPI_TX_UNDERRUN_FLAG_EN for a sticky underrun_o flag.
module spi_shift_transmitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  en_i,
  input  logic                  scl_neg_edge_detected_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic                  load_o,
  output logic                  underrun_o,
  output logic                  mosi_o
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_en_d;
  logic                  r_mosi;
  logic                  r_load;

  logic                  w_en_rise;
  logic                  w_event;
  logic                  w_cnt_zero;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_first_bit;
  logic                  w_next_bit;
  logic [DATA_WIDTH-1:0] w_hold_sh;
  logic [DATA_WIDTH-1:0] w_shift_sh;

  assign w_en_rise  = en_i & ~r_en_d;
  assign w_event    = en_i & (w_en_rise | scl_neg_edge_detected_i);
  assign w_cnt_zero = (r_bit_cnt == '0);
  assign w_accept   = data_valid_i & ~r_hold_full;
  assign w_load     = w_event & w_cnt_zero & r_hold_full;

  // The shifter keeps only the bits still to send, so the
  // next bit always sits at the outgoing end.
  assign w_first_bit = MSB_FIRST ? r_hold[DATA_WIDTH-1] : r_hold[0];
  assign w_next_bit  = MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0];
  assign w_hold_sh   = MSB_FIRST ? (r_hold << 1) : (r_hold >> 1);
  assign w_shift_sh  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_en_d      <= 1'b0;
      r_mosi      <= IDLE_LEVEL;
      r_load      <= 1'b0;
    end else begin
      r_en_d <= en_i;
      r_load <= w_load;
      if (w_accept) begin
        r_hold      <= data_i;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (!en_i) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_mosi    <= IDLE_LEVEL;
      end else if (w_event) begin
        if (!w_cnt_zero) begin
          r_mosi    <= w_next_bit;
          r_shift   <= w_shift_sh;
          r_bit_cnt <= r_bit_cnt - CW'(1);
        end else if (r_hold_full) begin
          r_mosi    <= w_first_bit;
          r_shift   <= w_hold_sh;
          r_bit_cnt <= LAST;
        end else begin
          r_mosi <= IDLE_LEVEL;
        end
      end
    end
  end

`ifdef SPI_TX_UNDERRUN_FLAG_EN
  logic r_underrun;
  logic w_underrun;

  assign w_underrun = w_event & w_cnt_zero & ~r_hold_full;

  // Set has priority so an underrun on the enabling edge is kept.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_underrun <= 1'b0;
    end else if (w_underrun) begin
      r_underrun <= 1'b1;
    end else if (w_en_rise) begin
      r_underrun <= 1'b0;
    end
  end

  assign underrun_o = r_underrun;
`else
  assign underrun_o = 1'b0;
`endif

  assign data_ready_o = ~r_hold_full;
  assign load_o       = r_load;
  assign mosi_o       = r_mosi;

endmodule

// File: tb/tb_spi_shift_transmitter.sv
// Directed bench for spi_shift_transmitter.
// Covers 8-bit MSB-first and 12-bit LSB-first instances.
module tb_spi_shift_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en8, scl8, v8;
  logic [7:0]  d8;
  logic        rdy8, ld8, ur8, mo8;
  logic        en12, scl12, v12;
  logic [11:0] d12;
  logic        rdy12, ld12, ur12, mo12;

  int n_vec = 0;
  int n_err = 0;

`ifdef SPI_TX_UNDERRUN_FLAG_EN
  localparam logic UF = 1'b1;
`else
  localparam logic UF = 1'b0;
`endif

  spi_shift_transmitter #(
    .DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
  ) u_dut8 (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en8),
    .scl_neg_edge_detected_i(scl8), .data_i(d8),
    .data_valid_i(v8), .data_ready_o(rdy8), .load_o(ld8),
    .underrun_o(ur8), .mosi_o(mo8)
  );

  spi_shift_transmitter #(
    .DATA_WIDTH(12), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
  ) u_dut12 (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en12),
    .scl_neg_edge_detected_i(scl12), .data_i(d12),
    .data_valid_i(v12), .data_ready_o(rdy12), .load_o(ld12),
    .underrun_o(ur12), .mosi_o(mo12)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sclk8(input logic eb, input logic el, input string tag);
    scl8 = 1'b1;
    tick();
    scl8 = 1'b0;
    chk({tag, ".mosi"}, 32'(mo8), 32'(eb));
    chk({tag, ".load"}, 32'(ld8), 32'(el));
    tick();
    chk({tag, ".hold"}, 32'(mo8), 32'(eb));
  endtask

  task automatic sclk12(input logic eb, input logic el, input string tag);
    scl12 = 1'b1;
    tick();
    scl12 = 1'b0;
    chk({tag, ".mosi"}, 32'(mo12), 32'(eb));
    chk({tag, ".load"}, 32'(ld12), 32'(el));
    tick();
  endtask

  logic [7:0]  w8;
  logic [11:0] w12;

  initial begin
    rst_n = 1'b0;
    en8 = 1'b0; scl8 = 1'b0; v8 = 1'b0; d8 = '0;
    en12 = 1'b0; scl12 = 1'b0; v12 = 1'b0; d12 = '0;
    tick();
    tick();
    chk("rst.mosi", 32'(mo8), 32'd1);
    chk("rst.rdy", 32'(rdy8), 32'd1);
    chk("rst.load", 32'(ld8), 32'd0);
    chk("rst.ur", 32'(ur8), 32'd0);
    chk("rst12.mosi", 32'(mo12), 32'd1);
    rst_n = 1'b1;
    tick();

    // 12-bit LSB-first; en rise coincides with an SCL pulse
    d12 = 12'h0F3; v12 = 1'b1;
    tick();
    v12 = 1'b0;
    chk("t2.rdy0", 32'(rdy12), 32'd0);
    en12 = 1'b1; scl12 = 1'b1;
    tick();
    scl12 = 1'b0;
    chk("t2.b0", 32'(mo12), 32'd1);
    chk("t2.ld", 32'(ld12), 32'd1);
    chk("t2.rdy1", 32'(rdy12), 32'd1);
    tick();
    w12 = 12'h0F3;
    for (int i = 1; i < 12; i++) sclk12(w12[i], 1'b0, "t2.bit");
    sclk12(1'b1, 1'b0, "t2.under");
    chk("t2.ur", 32'(ur12), 32'(UF));
    en12 = 1'b0;

    // 8-bit MSB-first basic word
    d8 = 8'hA5; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    chk("t1.rdy0", 32'(rdy8), 32'd0);
    tick();
    chk("t1.preidle", 32'(mo8), 32'd1);
    en8 = 1'b1;
    tick();
    chk("t1.b7", 32'(mo8), 32'd1);
    chk("t1.ld", 32'(ld8), 32'd1);
    chk("t1.rdy1", 32'(rdy8), 32'd1);
    w8 = 8'hA5;
    for (int i = 6; i >= 0; i--) sclk8(w8[i], 1'b0, "t1.bit");
    sclk8(1'b1, 1'b0, "t1.under");
    chk("t1.ur", 32'(ur8), 32'(UF));

    // back-to-back FF then 00
    en8 = 1'b0;
    tick();
    chk("t3.idle", 32'(mo8), 32'd1);
    d8 = 8'hFF; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    en8 = 1'b1;
    tick();
    chk("t3.b7", 32'(mo8), 32'd1);
    chk("t3.ld", 32'(ld8), 32'd1);
    chk("t3.urclr", 32'(ur8), 32'd0);
    d8 = 8'h00; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    chk("t3.rdy0", 32'(rdy8), 32'd0);
    for (int i = 0; i < 7; i++) sclk8(1'b1, 1'b0, "t3.ff");
    sclk8(1'b0, 1'b1, "t3.w2first");
    chk("t3.rdy1", 32'(rdy8), 32'd1);
    for (int i = 0; i < 7; i++) sclk8(1'b0, 1'b0, "t3.00");
    sclk8(1'b1, 1'b0, "t3.under");

    // underrun on the en rise itself
    en8 = 1'b0;
    tick();
    en8 = 1'b1;
    tick();
    chk("t4.mosi", 32'(mo8), 32'd1);
    chk("t4.ld", 32'(ld8), 32'd0);
    chk("t4.ur", 32'(ur8), 32'(UF));
    tick();
    chk("t4.ursticky", 32'(ur8), 32'(UF));
    sclk8(1'b1, 1'b0, "t4.pulse");
    chk("t4.ursticky2", 32'(ur8), 32'(UF));

    // abort mid-word, held word restarts from bit 7
    en8 = 1'b0;
    tick();
    d8 = 8'h3C; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    en8 = 1'b1;
    tick();
    chk("t5.b7", 32'(mo8), 32'd0);
    chk("t5.ld", 32'(ld8), 32'd1);
    chk("t5.urclr", 32'(ur8), 32'd0);
    d8 = 8'h81; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    sclk8(1'b0, 1'b0, "t5.b6");
    sclk8(1'b1, 1'b0, "t5.b5");
    en8 = 1'b0;
    tick();
    chk("t5.abort", 32'(mo8), 32'd1);
    chk("t5.abld", 32'(ld8), 32'd0);
    chk("t5.held", 32'(rdy8), 32'd0);
    tick();
    en8 = 1'b1;
    tick();
    chk("t5.n7", 32'(mo8), 32'd1);
    chk("t5.nld", 32'(ld8), 32'd1);
    chk("t5.nrdy", 32'(rdy8), 32'd1);
    for (int i = 0; i < 3; i++) sclk8(1'b0, 1'b0, "t5.n");

    // reset mid-frame
    rst_n = 1'b0; scl8 = 1'b1;
    tick();
    rst_n = 1'b1; scl8 = 1'b0;
    chk("t6.mosi", 32'(mo8), 32'd1);
    chk("t6.rdy", 32'(rdy8), 32'd1);
    chk("t6.ur", 32'(ur8), 32'd0);
    chk("t6.ld", 32'(ld8), 32'd0);
    tick();
    chk("t6.rise", 32'(mo8), 32'd1);
    chk("t6.riseld", 32'(ld8), 32'd0);
    chk("t6.riseur", 32'(ur8), 32'(UF));
    sclk8(1'b1, 1'b0, "t6.p0");
    sclk8(1'b1, 1'b0, "t6.p1");
    en8 = 1'b0;
    tick();
    d8 = 8'h5A; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    en8 = 1'b1;
    tick();
    chk("t6.nb7", 32'(mo8), 32'd0);
    chk("t6.nld", 32'(ld8), 32'd1);
    w8 = 8'h5A;
    for (int i = 6; i >= 0; i--) sclk8(w8[i], 1'b0, "t6.bit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
